// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Requester-side controller for a byte-addressed, big-endian data memory word
//   port. Accepts byte/halfword/word loads and stores on a valid/ready request
//   channel, performs sub-word stores as read-modify-write, sign/zero-extends
//   loads and rejects out-of-range requests without touching memory.
//
//   Optional build macro: MEM_ACCESS_ALIGN_CHECK_EN
//     defined   -> misaligned halfword (A[0]) / word (A[1:0]) requests are errors
//     undefined -> unaligned accesses are legal whenever the range check passes
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed        load sign-extension select
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid/ready  response handshake
//   resp_rdata        load result (0 for stores and errors)
//   resp_err          request rejected, memory untouched
//   mem_wen           memory write enable (one cycle per store)
//   mem_addr          memory word base address
//   mem_wdata         memory write data, byte at mem_addr in [31:24]
//   mem_rdata         combinational memory read data from mem_addr
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W    = 6,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0]        SZ_BYTE    = 2'b00;
  localparam logic [1:0]        SZ_HALF    = 2'b01;
  localparam logic [1:0]        SZ_WORD    = 2'b10;
  localparam logic [31:0]       LIMIT_BYTE = 32'(MEM_BYTES - 1);
  localparam logic [31:0]       LIMIT_HALF = 32'(MEM_BYTES - 2);
  localparam logic [31:0]       LIMIT_WORD = 32'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              ready_r;
  logic              we_r;
  logic [1:0]        size_r;
  logic              signed_r;
  logic [1:0]        lane_r;
  logic [31:0]       wdata_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;
  logic              mem_wen_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;

  logic [31:0]       addr_ext_s;
  logic              range_ok_s;
  logic              misalign_s;
  logic              err_s;
  logic              accept_s;
  logic [ADDR_W-1:0] base_s;
  logic [1:0]        lane_s;
  logic [31:0]       load_val_s;
  logic [31:0]       merge_val_s;

  // Pick the addressed field out of a big-endian word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    r = 32'h0000_0000;
    case (lane)
      2'd0:    begin b = word[31:24]; h = word[31:16]; end
      2'd1:    begin b = word[23:16]; h = word[23:8];  end
      2'd2:    begin b = word[15:8];  h = word[15:0];  end
      2'd3:    begin b = word[7:0];   h = 16'h0000;    end
      default: begin b = 8'h00;       h = 16'h0000;    end
    endcase
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Overlay right-justified store data onto the addressed lanes of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[31:24] = wd[7:0];
          2'd1:    r[23:16] = wd[7:0];
          2'd2:    r[15:8]  = wd[7:0];
          2'd3:    r[7:0]   = wd[7:0];
          default: r        = word;
        endcase
      end
      SZ_HALF: begin
        case (lane)
          2'd0:    r[31:16] = wd[15:0];
          2'd1:    r[23:8]  = wd[15:0];
          2'd2:    r[15:0]  = wd[15:0];
          default: r        = word;
        endcase
      end
      SZ_WORD: r = wd;
      default: r = word;
    endcase
    return r;
  endfunction

  assign addr_ext_s = {{(32-ADDR_W){1'b0}}, req_addr};
  assign accept_s   = req_valid && ready_r;
  assign err_s      = !range_ok_s || misalign_s;

  // Range check of the incoming request against the memory size.
  always_comb begin
    range_ok_s = 1'b0;
    case (req_size)
      SZ_BYTE: range_ok_s = (addr_ext_s <= LIMIT_BYTE);
      SZ_HALF: range_ok_s = (addr_ext_s <= LIMIT_HALF);
      SZ_WORD: range_ok_s = (addr_ext_s <= LIMIT_WORD);
      default: range_ok_s = 1'b0;
    endcase
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  // Natural-alignment check for halfword and word requests.
  always_comb begin
    misalign_s = 1'b0;
    if (req_size == SZ_HALF) begin
      misalign_s = req_addr[0];
    end else if (req_size == SZ_WORD) begin
      misalign_s = (req_addr[1:0] != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  assign misalign_s = 1'b0;
`endif

  // The word window is clamped to the top of memory; only accesses in the
  // last word land on a non-zero lane.
  always_comb begin
    base_s = req_addr;
    lane_s = 2'd0;
    if (addr_ext_s > LIMIT_WORD) begin
      base_s = LAST_BASE;
      lane_s = req_addr[1:0] - LAST_BASE[1:0];
    end else begin
      base_s = req_addr;
      lane_s = 2'd0;
    end
  end

  assign load_val_s  = load_extract(mem_rdata, size_r, lane_r, signed_r);
  assign merge_val_s = store_merge(mem_rdata, wdata_r, size_r, lane_r);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            state_s = ST_RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_s = ST_WR;
          end else begin
            state_s = ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (we_r) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_WR:   state_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered ready flag (high exactly in IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_IDLE);
    end
  end

  // Request field capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r     <= 1'b0;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      lane_r   <= 2'd0;
      wdata_r  <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r     <= req_we;
      size_r   <= req_size;
      signed_r <= req_signed;
      lane_r   <= lane_s;
      wdata_r  <= req_wdata;
    end
  end

  // Registered memory-port and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else begin
              mem_addr_r <= base_s;
              if (req_we && (req_size == SZ_WORD)) begin
                mem_wen_r   <= 1'b1;
                mem_wdata_r <= req_wdata;
              end
            end
          end
        end
        ST_RD: begin
          if (we_r) begin
            mem_wen_r   <= 1'b1;
            mem_wdata_r <= merge_val_s;
          end else begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= load_val_s;
          end
        end
        ST_WR: begin
          mem_wen_r    <= 1'b0;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          mem_wen_r    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_wen    = mem_wen_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 64-byte memory model drives the
// word port, and a byte-array reference model predicts every response, write
// and latency.
module tb_mem_access_unit;
  localparam int ADDR_W    = 6;
  localparam int MEM_BYTES = 64;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_clr;

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical memory seen by the DUT
  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (int'(mem_addr) + k < MEM_BYTES) mem_rdata[31-8*k -: 8] = mem[int'(mem_addr) + k];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < MEM_BYTES; k++) mem[k] <= 8'h00;
    end else if (mem_wen) begin
      for (int k = 0; k < 4; k++) begin
        if (int'(mem_addr) + k < MEM_BYTES) mem[int'(mem_addr) + k] <= mem_wdata[31-8*k -: 8];
      end
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        exp_err, exp_write;
  logic [31:0] exp_rdata, exp_wdata;
  int          exp_base, exp_lat;
  int          nchk, nerr, wen_seen, last_lat;
  logic [31:0] last_rdata, last_wdata, last_rd_addr, last_wen_addr;
  logic        last_err;
  logic        r_we, r_sgn;
  logic [1:0]  r_size;
  logic [31:0] r_wd;
  int          r_addr, r_hold;
  logic [7:0]  old_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of memory-port and response outputs against the model
  task automatic cycle_check();
    if (mem_wen) begin
      wen_seen++;
      last_wdata    = mem_wdata;
      last_wen_addr = 32'(mem_addr);
      chk("wen_expected", 32'(exp_write), 32'd1);
      chk("wen_addr", 32'(mem_addr), 32'(exp_base));
      chk("wen_data", mem_wdata, exp_wdata);
    end
    if (resp_valid) begin
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
  endtask

  // Predict the outcome of one request from the byte-array view of memory
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input int a, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_err = (size == 2'b11) || (a + n > MEM_BYTES);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (size == 2'b01 && (a % 2) != 0) exp_err = 1'b1;
    if (size == 2'b10 && (a % 4) != 0) exp_err = 1'b1;
`endif
    exp_base  = (a > MEM_BYTES - 4) ? MEM_BYTES - 4 : a;
    exp_write = !exp_err && we;
    exp_rdata = 32'h0;
    exp_wdata = 32'h0;
    if (exp_err) exp_lat = 1;
    else if (we && n < 4) exp_lat = 3;
    else exp_lat = 2;
    if (!exp_err && we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*(n-1-i) +: 8];
      for (int k = 0; k < 4; k++) exp_wdata = {exp_wdata[23:0], ref_mem[exp_base+k]};
    end else if (!exp_err) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = {v[23:0], ref_mem[a+i]};
      if (n < 4 && sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rdata = v;
    end
  endtask

  // Present a request from a negedge, let it be accepted, stop at cycle 1
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input int a, input logic [31:0] wd);
    model(we, size, sgn, a, wd);
    wen_seen = 0;
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = ADDR_W'(a); req_wdata = wd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    if (!exp_err && !(we && size == 2'b10)) begin
      chk("rd_addr", 32'(mem_addr), 32'(exp_base));
      chk("rd_nowen", 32'(mem_wen), 32'd0);
      last_rd_addr = 32'(mem_addr);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input int a, input logic [31:0] wd, input int hold, input logic poke);
    int lat, bad;
    issue(we, size, sgn, a, wd);
    lat = 1;
    while (!resp_valid && lat < 6) begin
      tick();
      lat++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    last_lat = lat; last_rdata = resp_rdata; last_err = resp_err;
    chk("ready_busy", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = '0;
      end
      tick();
      req_valid = 1'b0;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    tick();
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    chk("wen_count", 32'(wen_seen), exp_write ? 32'd1 : 32'd0);
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0; nerr = 0; wen_seen = 0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b0;
    exp_err = 1'b0; exp_write = 1'b0; exp_rdata = 32'h0; exp_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0; mem_clr = 1'b0;
    tick();

    // Directed scenarios with hand-computed results
    run_req(1'b1, 2'b10, 1'b0, 8, 32'hDEAD_BEEF, 0, 1'b0);
    chk("lit_wst_data", last_wdata, 32'hDEAD_BEEF);
    chk("lit_wst_addr", last_wen_addr, 32'd8);
    chk("lit_wst_lat", 32'(last_lat), 32'd2);
    run_req(1'b0, 2'b10, 1'b0, 8, 32'h0, 0, 1'b0);
    chk("lit_wld", last_rdata, 32'hDEAD_BEEF);
    run_req(1'b1, 2'b00, 1'b0, 9, 32'h0000_0080, 0, 1'b0);
    chk("lit_bst_lat", 32'(last_lat), 32'd3);
    run_req(1'b0, 2'b00, 1'b1, 9, 32'h0, 0, 1'b0);
    chk("lit_sbld", last_rdata, 32'hFFFF_FF80);
    run_req(1'b0, 2'b00, 1'b0, 9, 32'h0, 0, 1'b0);
    chk("lit_ubld", last_rdata, 32'h0000_0080);
    run_req(1'b0, 2'b10, 1'b0, 8, 32'h0, 0, 1'b0);
    chk("lit_merged_word", last_rdata, 32'hDE80_BEEF);
    run_req(1'b1, 2'b10, 1'b0, 60, 32'h1122_3344, 0, 1'b0);
    run_req(1'b0, 2'b01, 1'b0, 62, 32'h0, 0, 1'b0);
    chk("lit_hld62", last_rdata, 32'h0000_3344);
    chk("lit_hld62_addr", last_rd_addr, 32'd60);
    run_req(1'b0, 2'b01, 1'b0, 63, 32'h0, 0, 1'b0);
    chk("lit_hld63_err", 32'(last_err), 32'd1);
    chk("lit_hld63_data", last_rdata, 32'd0);
    run_req(1'b0, 2'b00, 1'b0, 63, 32'h0, 0, 1'b0);
    chk("lit_bld63", last_rdata, 32'h0000_0044);
    run_req(1'b1, 2'b10, 1'b0, 61, 32'hCAFE_F00D, 0, 1'b0);
    chk("lit_wst61_err", 32'(last_err), 32'd1);
    chk("lit_wst61_lat", 32'(last_lat), 32'd1);
    run_req(1'b0, 2'b11, 1'b0, 4, 32'h0, 0, 1'b0);
    chk("lit_size11_err", 32'(last_err), 32'd1);
    run_req(1'b0, 2'b10, 1'b0, 8, 32'h0, 5, 1'b1);
    chk("lit_hold_ld", last_rdata, 32'hDE80_BEEF);

    // Reset while a byte store is in its write cycle
    old_b = ref_mem[20];
    issue(1'b1, 2'b00, 1'b0, 20, 32'h0000_005A);
    tick();
    chk("wr_phase", 32'(mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wen_drop", 32'(mem_wen), 32'd0);
    chk("rst_valid_drop", 32'(resp_valid), 32'd0);
    chk("rst_err_drop", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_commit", 32'((mem[20] === old_b) || (mem[20] === 8'h5A)), 32'd1);
    ref_mem[20] = mem[20];
    tick();
    run_req(1'b0, 2'b10, 1'b0, 8, 32'h0, 0, 1'b0);
    chk("lit_post_rst", last_rdata, 32'hDE80_BEEF);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      r_we   = 1'($urandom);
      r_sgn  = 1'($urandom);
      r_size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 3) == 0) ? 56 + int'($urandom_range(0, 7))
                                           : int'($urandom_range(0, 63));
      r_wd   = $urandom;
      r_hold = int'($urandom_range(0, 3));
      run_req(r_we, r_size, r_sgn, r_addr, r_wd, r_hold, r_hold >= 2);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
